// File: rtl/hd_responder.sv
// Disk-style word responder: a 4096 x 32 store addressed as 64 tracks of 64 words.
// A request costs a fixed seek penalty when it lands on a track other than the one
// under the head, then a fixed access time, then a one-cycle completion pulse.
module hd_responder #(
    parameter int unsigned SEEK_CYCLES   = 4,  // must be >= 1
    parameter int unsigned ACCESS_CYCLES = 2   // must be >= 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] HDaddress,
    input  logic [31:0] HDoutdata,
    input  logic        HDwe,
    input  logic        HDre,
    output logic [31:0] HDIndata,
    output logic        HDbusy,
    output logic        HDready
);

    typedef enum logic [1:0] {StIdle, StSeek, StAccess, StDone} state_e;

    // Counters hold "cycles remaining minus one" so the last cycle is cnt == 0.
    localparam logic [15:0] SeekLast = 16'(SEEK_CYCLES - 1);
    localparam logic [15:0] AccLast  = 16'(ACCESS_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        write_q, write_d;
    logic [5:0]  head_q, head_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_we;

    logic [31:0] mem_q [4096];

    // Next-state and datapath decisions; memory write strobe only on ACCESS -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        head_d  = head_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (HDwe || HDre) begin
                    addr_d  = HDaddress;
                    data_d  = HDoutdata;
                    write_d = HDwe;  // write wins when both are requested
                    if (HDaddress[11:6] != head_q) begin
                        state_d = StSeek;
                        cnt_d   = SeekLast;
                    end else begin
                        state_d = StAccess;
                        cnt_d   = AccLast;
                    end
                end
            end
            StSeek: begin
                if (cnt_q == 16'd0) begin
                    state_d = StAccess;
                    cnt_d   = AccLast;
                    head_d  = addr_q[11:6];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StAccess: begin
                if (cnt_q == 16'd0) begin
                    state_d = StDone;
                    if (write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and request registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            addr_q  <= 12'd0;
            data_q  <= 32'd0;
            write_q <= 1'b0;
            head_q  <= 6'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
            head_q  <= head_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign HDIndata = rdata_q;
    assign HDbusy   = (state_q == StSeek) || (state_q == StAccess);
    assign HDready  = (state_q == StDone);

endmodule

// File: tb/tb_hd_responder.sv
// Randomized bench for hd_responder with a word-level reference model of the
// store, the head position and the returned read data.
module tb_hd_responder;

    localparam int unsigned SEEK = 4;
    localparam int unsigned ACC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] HDaddress = '0;
    logic [31:0] HDoutdata = '0;
    logic        HDwe = 1'b0;
    logic        HDre = 1'b0;
    logic [31:0] HDIndata;
    logic        HDbusy;
    logic        HDready;

    hd_responder #(
        .SEEK_CYCLES  (SEEK),
        .ACCESS_CYCLES(ACC)
    ) u_dut (
        .clock    (clk),
        .reset    (rst_n),
        .HDaddress(HDaddress),
        .HDoutdata(HDoutdata),
        .HDwe     (HDwe),
        .HDre     (HDre),
        .HDIndata (HDIndata),
        .HDbusy   (HDbusy),
        .HDready  (HDready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mem_m   [4096];
    bit          valid_m [4096];
    logic [5:0]  head_m;
    logic [31:0] rd_m;
    bit          rd_known;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction: accept, scramble inputs, measure latency/busy, update model.
    task automatic run_op(input bit we, input bit re, input logic [11:0] addr,
                          input logic [31:0] data, input bit pulse_mid, input string tag);
        int n;
        int busy_cnt;
        int exp_lat;
        int exp_busy;
        exp_busy = (addr[11:6] != head_m) ? int'(SEEK + ACC) : int'(ACC);
        exp_lat  = exp_busy + 1;
        @(negedge clk);
        HDwe = we;
        HDre = re;
        HDaddress = addr;
        HDoutdata = data;
        @(posedge clk);
        #1;
        HDwe = 1'b0;
        HDre = 1'b0;
        HDaddress = 12'($urandom);
        HDoutdata = $urandom;
        n = 1;
        busy_cnt = 0;
        while (HDready !== 1'b1 && n < 64) begin
            if (HDbusy === 1'b1) busy_cnt++;
            if (pulse_mid && n == exp_busy - 1) begin
                HDre = 1'b1;
                HDaddress = 12'($urandom);
            end
            if (pulse_mid && n == exp_busy) HDre = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        HDre = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " busy_in_done"}, {31'd0, HDbusy}, 32'd0);
        head_m = addr[11:6];
        if (we) begin
            mem_m[addr] = data;
            valid_m[addr] = 1'b1;
        end else begin
            rd_m = mem_m[addr];
            rd_known = valid_m[addr];
        end
        if (rd_known) check({tag, " rdata"}, HDIndata, rd_m);
        @(posedge clk);
        #1;
        check({tag, " ready_pulse"}, {31'd0, HDready}, 32'd0);
        check({tag, " idle_busy"}, {31'd0, HDbusy}, 32'd0);
    endtask

    logic [11:0] pool [8];

    initial begin
        logic [31:0] old_fc0;
        for (int i = 0; i < 4096; i++) valid_m[i] = 1'b0;
        head_m = 6'd0;
        rd_m = 32'd0;
        rd_known = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", HDIndata, 32'd0);
        check("reset busy", {31'd0, HDbusy}, 32'd0);
        check("reset ready", {31'd0, HDready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read on track 0
        run_op(1'b1, 1'b0, 12'h005, 32'hDEADBEEF, 1'b0, "wr005");
        run_op(1'b0, 1'b1, 12'h005, 32'h0, 1'b0, "rd005");
        // Seek to track 31, then same-track read
        run_op(1'b0, 1'b1, 12'h7C0, 32'h0, 1'b0, "rd7C0");
        run_op(1'b0, 1'b1, 12'h7FF, 32'h0, 1'b0, "rd7FF");
        // Write wins over read; HDIndata must hold
        run_op(1'b1, 1'b1, 12'h010, 32'h12345678, 1'b0, "both010");
        run_op(1'b1, 1'b0, 12'h101, 32'h0BADF00D, 1'b0, "wr101");
        run_op(1'b1, 1'b0, 12'h100, 32'hAAAA5555, 1'b0, "wr100");
        run_op(1'b0, 1'b1, 12'h100, 32'h0, 1'b0, "rd100");
        run_op(1'b0, 1'b1, 12'h101, 32'h0, 1'b0, "rd101");
        run_op(1'b0, 1'b1, 12'h010, 32'h0, 1'b0, "rd010");
        // Ignored mid-access request
        run_op(1'b0, 1'b1, 12'h012, 32'h0, 1'b1, "pulse");
        // Track 0 <-> 63 fixed seek
        run_op(1'b1, 1'b0, 12'hFC0, 32'hC0FFEE01, 1'b0, "wrFC0");
        run_op(1'b0, 1'b1, 12'h005, 32'h0, 1'b0, "rd005b");
        old_fc0 = 32'hC0FFEE01;

        // Reset mid-seek of a write to 0xFC0
        @(negedge clk);
        HDwe = 1'b1;
        HDaddress = 12'hFC0;
        HDoutdata = 32'h55555555;
        @(posedge clk);
        #1;
        HDwe = 1'b0;
        @(posedge clk);
        #1;
        check("seek busy", {31'd0, HDbusy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, HDbusy}, 32'd0);
        check("abort ready", {31'd0, HDready}, 32'd0);
        check("abort rdata", HDIndata, 32'd0);
        head_m = 6'd0;
        rd_m = 32'd0;
        rd_known = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op(1'b0, 1'b1, 12'hFC0, 32'h0, 1'b0, "rdFC0");
        check("fc0 kept", HDIndata, old_fc0);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 8; i++) pool[i] = 12'($urandom);
        for (int i = 0; i < 40; i++) begin
            bit we;
            bit re;
            we = 1'($urandom);
            re = 1'($urandom);
            if (!we && !re) re = 1'b1;
            run_op(we, re, pool[$urandom_range(7, 0)], $urandom, 1'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
